axi_mem_master: RTL and testbench
=================================

// Module: axi_mem_master
// PURPOSE
// - AXI initiator on the memory side of the DRAM cache; drives AR/R/AW/W/B toward AXI_SLAVE_MEM.
// - Converts single cache-line requests into AXI transactions. Read responses return tag + data.
// - Exactly one transaction is outstanding at a time. No bursts: each transaction carries one 64 B beat.
// PARAMETERS
// - ADDR_W       64     address width
// - DATA_W       512    line data width
// - TAG_S        64     tag word width, prepended to read data
// - ID_W         16     AXI ID width
// - AXI_ID       1      constant value driven on arid_o/awid_o/wid_o
// - TIMEOUT_CYC  1024   watchdog limit in cycles (used only with AXI_MST_TIMEOUT_EN)
// PORTS
// - clk          in   1               clock; all logic on posedge
// - rst          in   1               synchronous reset, active-high
// - req_valid_i  in   1               request valid
// - req_ready_o  out  1               request accepted when valid&ready
// - req_write_i  in   1               1 = write line, 0 = read line
// - req_dirty_i  in   1               write only: mark the stored line dirty
// - req_addr_i   in   ADDR_W          byte address; bit ADDR_W-1 is ignored
// - req_wdata_i  in   DATA_W          write data
// - rsp_valid_o  out  1               response valid
// - rsp_ready_i  in   1               response consumed when valid&ready
// - rsp_write_o  out  1               1 = write ack, 0 = read data
// - rsp_rdata_o  out  TAG_S+DATA_W    {tag, data} for reads; 0 for writes
// - rsp_err_o    out  1               timeout flag; constant 0 without the macro
// - arid_o/araddr_o/arvalid_o  out  ID_W/ADDR_W/1;  arready_i  in  1
// - rid_i  in  ID_W (ignored);  rdata_i  in  TAG_S+DATA_W;  rvalid_i  in  1;  rready_o  out  1
// - awid_o/awaddr_o/awvalid_o  out  ID_W/ADDR_W/1;  awready_i  in  1
// - wid_o/wdata_o/wvalid_o  out  ID_W/DATA_W/1;  wready_i  in  1
// - bid_i  in  ID_W (ignored);  bvalid_i  in  1;  bready_o  out  1
// BEHAVIOUR
// - States: S_IDLE, S_AR, S_R, S_W, S_B, S_RSP.
// - Reset: state=S_IDLE; all valid/ready outputs 0 except req_ready_o=1; rsp data and latched request regs 0.
// - Reset mid-transaction: the transaction is abandoned, with no completion or response.
// - S_IDLE: req_ready_o=1. On req_valid_i, latch write/dirty/addr/wdata.
//   - Next state: S_W if write, else S_AR.
// - S_AR: arvalid_o=1, araddr_o=latched addr. Hold address and valid stable until arready_i, then go to S_R.
// - S_R: rready_o=1. On rvalid_i, capture rdata_i into rsp_rdata_o and go to S_RSP.
// - S_W: awvalid_o and wvalid_o raised together.
//   - awaddr_o = {latched dirty, latched addr[ADDR_W-2:0]}; the slave decodes the MSB as the dirty set.
//   - aw_done/w_done flags record each handshake. Each valid drops the cycle after its own handshake.
//   - Go to S_B once both are done; both handshakes in the same cycle is legal.
// - S_B: bready_o=1. On bvalid_i go to S_RSP.
// - S_RSP: rsp_valid_o=1; rsp_* outputs stay stable until rsp_ready_i, then go to S_IDLE.
//   - req_ready_o stays 0 until the state is back in S_IDLE, so there is no back-to-back bypass.
// - Min latency with a zero-wait slave:
//   - Read: accept at cycle 0, AR cycle 1, R cycle 2, rsp_valid_o cycle 3.
//   - Write: accept at cycle 0, AW/W cycle 1, B cycle 2, rsp_valid_o cycle 3.
// - Handshakes occurring in a state where they are not expected are ignored.
// - rid_i/bid_i are not checked.
// - All ID outputs are constant AXI_ID.
// CONFIGURATION
// - Macro AXI_MST_TIMEOUT_EN, defined:
//   - A 32-bit counter clears on entering S_AR or S_W and increments every cycle in S_AR/S_R/S_W/S_B.
//   - When the count reaches TIMEOUT_CYC-1, force S_RSP with rsp_err_o=1 and rsp_rdata_o=0.
//   - All AXI valid/ready outputs drop in that same transition.
//   - rsp_err_o clears when the next request is accepted.
// - AXI_MST_TIMEOUT_EN undefined: no counter; rsp_err_o tied to 0; waits forever.
// TESTING
// - Write addr 0x1040, dirty=0, data 0xA5 repeated:
//   - awaddr_o=0x1040; one AW and one W handshake; rsp_write_o=1, rsp_err_o=0.
// - Read 0x1040 after the write above -> rsp_rdata_o[575:512]=0x8000_0000_0000_0000, [511:0]=0xA5 repeated.
// - Write 0x1040 with dirty=1, then read it back:
//   - awaddr_o=0x8000_0000_0000_1040.
//   - Read tag = 0xE000_0000_0000_0000: valid, dirty and tag bit 61 set.
// - Slave stalls 5 cycles on arready, and rsp_ready_i held low 3 cycles:
//   - araddr_o and rsp_* stay stable throughout; req_ready_o=0 until S_IDLE.
// - rst=1 while in S_B -> next cycle state is S_IDLE, bready_o=0, req_ready_o=1, no rsp_valid_o.
// - With AXI_MST_TIMEOUT_EN, TIMEOUT_CYC=16, slave never raises arready:
//   - rsp_valid_o with rsp_err_o=1 after 16 cycles in S_AR; arvalid_o=0.

Source files
------------

// File: rtl/axi_mem_master.sv
// Single-beat AXI initiator: turns one cache-line read/write request into one AXI transaction.
// Optional watchdog enabled by defining AXI_MST_TIMEOUT_EN (times out after TIMEOUT_CYC cycles).
module axi_mem_master #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 512,
   parameter int TAG_S       = 64,
   parameter int ID_W        = 16,
   parameter int AXI_ID      = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   // request side
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_write_i,
   input  logic                    req_dirty_i,
   input  logic [ADDR_W-1:0]       req_addr_i,
   input  logic [DATA_W-1:0]       req_wdata_i,
   // response side
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic                    rsp_write_o,
   output logic [TAG_S+DATA_W-1:0] rsp_rdata_o,
   output logic                    rsp_err_o,
   // AXI read address / data
   output logic [ID_W-1:0]         arid_o,
   output logic [ADDR_W-1:0]       araddr_o,
   output logic                    arvalid_o,
   input  logic                    arready_i,
   input  logic [ID_W-1:0]         rid_i,
   input  logic [TAG_S+DATA_W-1:0] rdata_i,
   input  logic                    rvalid_i,
   output logic                    rready_o,
   // AXI write address / data / response
   output logic [ID_W-1:0]         awid_o,
   output logic [ADDR_W-1:0]       awaddr_o,
   output logic                    awvalid_o,
   input  logic                    awready_i,
   output logic [ID_W-1:0]         wid_o,
   output logic [DATA_W-1:0]       wdata_o,
   output logic                    wvalid_o,
   input  logic                    wready_i,
   input  logic [ID_W-1:0]         bid_i,
   input  logic                    bvalid_i,
   output logic                    bready_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_W    = 3'd3;
   localparam logic [2:0] S_B    = 3'd4;
   localparam logic [2:0] S_RSP  = 3'd5;

   localparam logic [31:0] TIMEOUT_L = TIMEOUT_CYC;

   logic [2:0]              state_reg;
   logic [2:0]              state_next;
   logic                    wr_reg;
   logic                    dirty_reg;
   logic [ADDR_W-2:0]       addr_reg;
   logic [DATA_W-1:0]       wdata_reg;
   logic                    aw_done_reg;
   logic                    w_done_reg;
   logic [TAG_S+DATA_W-1:0] rdata_reg;
   logic                    timeout_hit;
   logic                    req_fire;

   assign req_fire = (state_reg == S_IDLE) && req_valid_i;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (req_valid_i) state_next = req_write_i ? S_W : S_AR;
         S_AR:   if (arready_i)   state_next = S_R;
         S_R:    if (rvalid_i)    state_next = S_RSP;
         // A handshake seen in this cycle counts as done even before its flag registers.
         S_W:    if ((aw_done_reg || awready_i) && (w_done_reg || wready_i)) state_next = S_B;
         S_B:    if (bvalid_i)    state_next = S_RSP;
         S_RSP:  if (rsp_ready_i) state_next = S_IDLE;
         default:                 state_next = S_IDLE;
      endcase
      if (timeout_hit) state_next = S_RSP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         wr_reg      <= 1'b0;
         dirty_reg   <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (req_fire) begin
            wr_reg      <= req_write_i;
            dirty_reg   <= req_dirty_i;
            addr_reg    <= req_addr_i[ADDR_W-2:0];
            wdata_reg   <= req_wdata_i;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            rdata_reg   <= '0;
         end
         if (state_reg == S_R && rvalid_i) rdata_reg <= rdata_i;
         if (state_reg == S_W) begin
            if (awready_i) aw_done_reg <= 1'b1;
            if (wready_i)  w_done_reg  <= 1'b1;
         end
         if (timeout_hit) rdata_reg <= '0;
      end
   end

`ifdef AXI_MST_TIMEOUT_EN
   logic [31:0] tcnt_reg;
   logic        err_reg;

   assign timeout_hit = (state_reg inside {S_AR, S_R, S_W, S_B}) &&
                        (tcnt_reg == TIMEOUT_L - 32'd1);

   // Every wait state is entered from S_IDLE, so clearing there covers entry into S_AR/S_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_reg <= '0;
         err_reg  <= 1'b0;
      end else begin
         if (state_reg == S_IDLE)
            tcnt_reg <= '0;
         else if (state_reg inside {S_AR, S_R, S_W, S_B})
            tcnt_reg <= tcnt_reg + 32'd1;
         if (req_fire)
            err_reg <= 1'b0;
         else if (timeout_hit)
            err_reg <= 1'b1;
      end
   end

   assign rsp_err_o = err_reg;
`else
   logic unused_tmo;

   assign timeout_hit = 1'b0;
   assign rsp_err_o   = 1'b0;
   assign unused_tmo  = ^TIMEOUT_L;
`endif

   logic unused_in;
   assign unused_in = ^{rid_i, bid_i, req_addr_i[ADDR_W-1]};

   assign req_ready_o = (state_reg == S_IDLE);
   assign arvalid_o   = (state_reg == S_AR);
   assign araddr_o    = {1'b0, addr_reg};
   assign rready_o    = (state_reg == S_R);
   // The slave decodes the address MSB as the dirty bit of the stored line.
   assign awvalid_o   = (state_reg == S_W) && !aw_done_reg;
   assign awaddr_o    = {dirty_reg, addr_reg};
   assign wvalid_o    = (state_reg == S_W) && !w_done_reg;
   assign wdata_o     = wdata_reg;
   assign bready_o    = (state_reg == S_B);
   assign rsp_valid_o = (state_reg == S_RSP);
   assign rsp_write_o = wr_reg;
   assign rsp_rdata_o = rdata_reg;

   assign arid_o = ID_W'(AXI_ID);
   assign awid_o = ID_W'(AXI_ID);
   assign wid_o  = ID_W'(AXI_ID);

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed bench for axi_mem_master with a small single-line-per-address AXI slave model.
module tb_axi_mem_master;
   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid_i, req_ready_o, req_write_i, req_dirty_i;
   logic [63:0]  req_addr_i;
   logic [511:0] req_wdata_i;
   logic         rsp_valid_o, rsp_ready_i, rsp_write_o, rsp_err_o;
   logic [575:0] rsp_rdata_o;
   logic [15:0]  arid_o, awid_o, wid_o, rid_i, bid_i;
   logic [63:0]  araddr_o, awaddr_o;
   logic         arvalid_o, arready_i, rvalid_i, rready_o;
   logic [575:0] rdata_i;
   logic         awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
   logic [511:0] wdata_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_mem_master #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_dirty_i(req_dirty_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
   );

   // slave model: stored tag = {valid, dirty, dirty, 61'b0}, dirty taken from awaddr MSB
   logic         ar_hold = 1'b0, w_hold = 1'b0, b_hold = 1'b0;
   logic         b_pend, aw_got, w_got;
   logic [63:0]  aw_addr_s;
   logic [511:0] w_data_s;
   logic [575:0] mem [longint];
   int           aw_cnt = 0, w_cnt = 0;

   assign arready_i = arvalid_o & ~ar_hold;
   assign awready_i = awvalid_o;
   assign wready_i  = wvalid_o & ~w_hold;
   assign rvalid_i  = rready_o;
   assign bvalid_i  = b_pend & ~b_hold;
   assign rid_i     = 16'h00AA;
   assign bid_i     = 16'h0055;

   always @(posedge clk) begin : slave
      logic         aw_hs, w_hs;
      logic [63:0]  a;
      logic [511:0] d;
      longint       key;
      if (rst) begin
         b_pend <= 1'b0;
         aw_got <= 1'b0;
         w_got  <= 1'b0;
      end else begin
         aw_hs = awvalid_o & awready_i;
         w_hs  = wvalid_o & wready_i;
         if (aw_hs) begin aw_addr_s <= awaddr_o; aw_cnt <= aw_cnt + 1; end
         if (w_hs)  begin w_data_s  <= wdata_o;  w_cnt  <= w_cnt + 1;  end
         if (arvalid_o && arready_i) begin
            key = longint'({1'b0, araddr_o[62:0]});
            rdata_i <= mem.exists(key) ? mem[key] : '0;
         end
         if (bvalid_i && bready_o) b_pend <= 1'b0;
         if ((aw_got | aw_hs) && (w_got | w_hs)) begin
            a = aw_got ? aw_addr_s : awaddr_o;
            d = w_got ? w_data_s : wdata_o;
            key = longint'({1'b0, a[62:0]});
            mem[key] = {1'b1, a[63], a[63], 61'b0, d};
            b_pend <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
         end
      end
   end

   // Leaves the bench at the negedge one cycle after acceptance.
   task automatic issue(input logic wr, input logic dirty, input logic [63:0] a,
                        input logic [511:0] d);
      int n = 0;
      while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
      req_valid_i = 1'b1; req_write_i = wr; req_dirty_i = dirty;
      req_addr_i = a; req_wdata_i = d;
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   // Number of negedges waited until rsp_valid_o (capped at 200).
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid_o && lat < 200) begin @(negedge clk); lat++; end
   endtask

   task automatic consume();
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if ({req_ready_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, rsp_valid_o} !== 7'b1000000) begin
         failures++; $display("FAIL reset_hs got=%b exp=1000000", {req_ready_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, rsp_valid_o}); end
      checks++; if (rsp_rdata_o !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata_o); end
      checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rsp_err_o); end
      checks++; if ({arid_o, awid_o, wid_o} !== {16'd1, 16'd1, 16'd1}) begin
         failures++; $display("FAIL reset_ids got=%h exp=000100010001", {arid_o, awid_o, wid_o}); end
      checks++; if (awaddr_o !== 64'h0) begin failures++; $display("FAIL reset_awaddr got=%h exp=0", awaddr_o); end
   endtask

   task automatic test_write_clean();
      int a0 = aw_cnt, w0 = w_cnt, lat;
      issue(1'b1, 1'b0, 64'h1040, {64{8'hA5}});
      checks++; if ({awvalid_o, wvalid_o, arvalid_o} !== 3'b110) begin failures++; $display("FAIL wr_valids got=%b exp=110", {awvalid_o, wvalid_o, arvalid_o}); end
      checks++; if (awaddr_o !== 64'h1040) begin failures++; $display("FAIL wr_awaddr got=%h exp=1040", awaddr_o); end
      checks++; if (wdata_o !== {64{8'hA5}}) begin failures++; $display("FAIL wr_wdata got=%h", wdata_o); end
      wait_rsp(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
      checks++; if ({rsp_write_o, rsp_err_o, req_ready_o} !== 3'b100) begin failures++; $display("FAIL wr_rsp got=%b exp=100", {rsp_write_o, rsp_err_o, req_ready_o}); end
      checks++; if (rsp_rdata_o !== '0) begin failures++; $display("FAIL wr_rdata got=%h exp=0", rsp_rdata_o); end
      checks++; if ((aw_cnt - a0) !== 1 || (w_cnt - w0) !== 1) begin failures++; $display("FAIL wr_hs_count aw=%0d w=%0d exp=1/1", aw_cnt - a0, w_cnt - w0); end
      consume();
      checks++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin failures++; $display("FAIL wr_done got=%b exp=01", {rsp_valid_o, req_ready_o}); end
   endtask

   task automatic test_read(input string nm, input logic [63:0] a, input logic [63:0] tag,
                            input logic [511:0] d);
      int lat;
      issue(1'b0, 1'b0, a, '0);
      checks++; if ({arvalid_o, awvalid_o, araddr_o} !== {2'b10, a}) begin
         failures++; $display("FAIL %s_ar got=%b/%b/%h exp=1/0/%h", nm, arvalid_o, awvalid_o, araddr_o, a); end
      wait_rsp(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL %s_latency got=%0d exp=2", nm, lat); end
      checks++; if (rsp_rdata_o[575:512] !== tag) begin failures++; $display("FAIL %s_tag got=%h exp=%h", nm, rsp_rdata_o[575:512], tag); end
      checks++; if (rsp_rdata_o[511:0] !== d) begin failures++; $display("FAIL %s_data got=%h exp=%h", nm, rsp_rdata_o[511:0], d); end
      checks++; if ({rsp_write_o, rsp_err_o} !== 2'b00) begin failures++; $display("FAIL %s_flags got=%b exp=00", nm, {rsp_write_o, rsp_err_o}); end
      consume();
   endtask

   task automatic test_write_dirty();
      int lat;
      issue(1'b1, 1'b1, 64'h1040, {64{8'h3C}});
      checks++; if (awaddr_o !== 64'h8000_0000_0000_1040) begin failures++; $display("FAIL dirty_awaddr got=%h exp=8000000000001040", awaddr_o); end
      wait_rsp(lat);
      checks++; if ({lat, rsp_write_o} !== {32'd2, 1'b1}) begin failures++; $display("FAIL dirty_rsp lat=%0d wr=%b exp=2/1", lat, rsp_write_o); end
      consume();
      test_read("rd_dirty", 64'h1040, 64'hE000_0000_0000_0000, {64{8'h3C}});
   endtask

   task automatic test_split_aw_w();
      int a0 = aw_cnt, w0 = w_cnt, lat;
      w_hold = 1'b1;
      issue(1'b1, 1'b0, 64'h2000, {64{8'h5A}});
      checks++; if ({awvalid_o, wvalid_o} !== 2'b11) begin failures++; $display("FAIL split_c1 got=%b exp=11", {awvalid_o, wvalid_o}); end
      @(negedge clk);
      checks++; if ({awvalid_o, wvalid_o} !== 2'b01) begin failures++; $display("FAIL split_c2 got=%b exp=01", {awvalid_o, wvalid_o}); end
      checks++; if ((aw_cnt - a0) !== 1 || (w_cnt - w0) !== 0) begin failures++; $display("FAIL split_cnt aw=%0d w=%0d exp=1/0", aw_cnt - a0, w_cnt - w0); end
      @(negedge clk);
      checks++; if ({awvalid_o, wvalid_o, bready_o} !== 3'b010) begin failures++; $display("FAIL split_c3 got=%b exp=010", {awvalid_o, wvalid_o, bready_o}); end
      w_hold = 1'b0;
      wait_rsp(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL split_latency got=%0d exp=2", lat); end
      checks++; if ((aw_cnt - a0) !== 1 || (w_cnt - w0) !== 1) begin failures++; $display("FAIL split_total aw=%0d w=%0d exp=1/1", aw_cnt - a0, w_cnt - w0); end
      consume();
      test_read("rd_split", 64'h2000, 64'h8000_0000_0000_0000, {64{8'h5A}});
   endtask

   task automatic test_stall();
      int lat;
      ar_hold = 1'b1;
      issue(1'b0, 1'b0, 64'h1040, '0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         checks++; if ({arvalid_o, req_ready_o, araddr_o} !== {2'b10, 64'h1040}) begin
            failures++; $display("FAIL stall_ar%0d got=%b/%b/%h exp=1/0/1040", i, arvalid_o, req_ready_o, araddr_o); end
      end
      ar_hold = 1'b0;
      wait_rsp(lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL stall_latency got=%0d exp=2", lat); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({rsp_valid_o, req_ready_o, rsp_write_o, rsp_rdata_o} !== {3'b100, 64'hE000_0000_0000_0000, {64{8'h3C}}}) begin
            failures++; $display("FAIL stall_rsp%0d got=%b/%b/%b tag=%h", i, rsp_valid_o, req_ready_o, rsp_write_o, rsp_rdata_o[575:512]); end
      end
      consume();
      checks++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin failures++; $display("FAIL stall_done got=%b exp=01", {rsp_valid_o, req_ready_o}); end
   endtask

   task automatic test_reset_in_b();
      int n = 0;
      b_hold = 1'b1;
      issue(1'b1, 1'b0, 64'h3000, {64{8'h11}});
      while (!bready_o && n < 20) begin @(negedge clk); n++; end
      checks++; if (bready_o !== 1'b1) begin failures++; $display("FAIL rstb_reach got=%b exp=1", bready_o); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({bready_o, req_ready_o, rsp_valid_o, awvalid_o} !== 4'b0100) begin
         failures++; $display("FAIL rstb_state got=%b exp=0100", {bready_o, req_ready_o, rsp_valid_o, awvalid_o}); end
      rst = 1'b0;
      b_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin failures++; $display("FAIL rstb_quiet%0d got=%b exp=01", i, {rsp_valid_o, req_ready_o}); end
      end
   endtask

`ifdef AXI_MST_TIMEOUT_EN
   task automatic test_timeout();
      int lat;
      ar_hold = 1'b1;
      issue(1'b0, 1'b0, 64'h1040, '0);
      wait_rsp(lat);
      checks++; if (lat !== 16) begin failures++; $display("FAIL tmo_latency got=%0d exp=16", lat); end
      checks++; if ({rsp_err_o, arvalid_o} !== 2'b10) begin failures++; $display("FAIL tmo_flags got=%b exp=10", {rsp_err_o, arvalid_o}); end
      checks++; if (rsp_rdata_o !== '0) begin failures++; $display("FAIL tmo_rdata got=%h exp=0", rsp_rdata_o); end
      consume();
      ar_hold = 1'b0;
      issue(1'b0, 1'b0, 64'h1040, '0);
      checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", rsp_err_o); end
      wait_rsp(lat);
      checks++; if ({lat, rsp_err_o} !== {32'd2, 1'b0}) begin failures++; $display("FAIL tmo_next lat=%0d err=%b exp=2/0", lat, rsp_err_o); end
      consume();
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid_i = 1'b0; req_write_i = 1'b0; req_dirty_i = 1'b0;
      req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_write_clean();
      test_read("rd_clean", 64'h1040, 64'h8000_0000_0000_0000, {64{8'hA5}});
      test_write_dirty();
      test_split_aw_w();
      test_stall();
      test_reset_in_b();
`ifdef AXI_MST_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
